// File: rtl/regfile_wb_queue.sv
// Write-back queue that sits directly in front of the multi-ported register file.
// It takes in-order write-back requests from the execute stage, one per cycle.
// Each cycle it drains up to N_WRITE_PORTS of the oldest entries onto the write ports.
// Two writes to the same register never issue in the same cycle.
// A youngest-match lookup lets the read stage forward data that is still queued.
// Optional feature: define WB_BYPASS_EN for a zero-latency bypass into an empty queue.
// In the default build, every request passes through the FIFO.
module regfile_wb_queue #(
  parameter int N_REGS        = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int N_WRITE_PORTS = 2,
  parameter int DEPTH         = 8,
  localparam int ADDR_WIDTH   = $clog2(N_REGS),
  localparam int CNT_WIDTH    = $clog2(DEPTH) + 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      inValid,
  output logic                                      inReady,
  input  logic [ADDR_WIDTH-1:0]                     inAddr,
  input  logic [DATA_WIDTH-1:0]                     inData,
  input  logic                                      stall,
  output logic                                      en,
  output logic [N_WRITE_PORTS-1:0]                  we,
  output logic [N_WRITE_PORTS-1:0][ADDR_WIDTH-1:0]  wAddrs,
  output logic [N_WRITE_PORTS-1:0][DATA_WIDTH-1:0]  wPorts,
  input  logic [ADDR_WIDTH-1:0]                     qAddr,
  output logic                                      qHit,
  output logic [DATA_WIDTH-1:0]                     qData,
  output logic [CNT_WIDTH-1:0]                      count
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [ADDR_WIDTH-1:0] memAddr [DEPTH];
  logic [DATA_WIDTH-1:0] memData [DEPTH];
  logic [PTR_WIDTH-1:0]  head;
  logic [PTR_WIDTH-1:0]  tail;
  logic [CNT_WIDTH-1:0]  popCount;
  logic                  bypass;
  logic                  push;

  // Back-pressure depends only on the registered count, so same-cycle draining never frees a slot.
  assign inReady = (count < CNT_WIDTH'(DEPTH));

`ifdef WB_BYPASS_EN
  assign bypass = inValid && !stall && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  // A bypassed request goes straight to port 0 and is never enqueued.
  assign push = inValid && inReady && !bypass;
  assign en   = |we;

  // Drain selection takes the oldest contiguous run of entries.
  // The run stops at the occupancy, at the port count, or at the first repeated address.
  always_comb begin
    logic                 stop;
    logic [PTR_WIDTH-1:0] idx;
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    we       = '0;
    wAddrs   = '0;
    wPorts   = '0;
    popCount = '0;
    stop     = stall;
    idx      = head;
    for (int i = 0; i < N_WRITE_PORTS; i++) begin
      idx       = head + PTR_WIDTH'(i);
      wAddrs[i] = memAddr[idx];
      wPorts[i] = memData[idx];
      if (CNT_WIDTH'(i) >= count) stop = 1'b1;
      for (int p = 0; p < i; p++) begin
        if (memAddr[head + PTR_WIDTH'(p)] == memAddr[idx]) stop = 1'b1;
      end
      if (!stop) begin
        we[i]    = 1'b1;
        popCount = popCount + 1'b1;
      end
    end
    if (bypass) begin
      we[0]     = 1'b1;
      wAddrs[0] = inAddr;
      wPorts[0] = inData;
    end
  end

  // Forwarding lookup scans from oldest to youngest, so the youngest match overrides earlier ones.
  always_comb begin
    logic [PTR_WIDTH-1:0] fIdx;
    qHit  = 1'b0;
    qData = '0;
    fIdx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      fIdx = head + PTR_WIDTH'(i);
      if ((CNT_WIDTH'(i) < count) && (memAddr[fIdx] == qAddr)) begin
        qHit  = 1'b1;
        qData = memData[fIdx];
      end
    end
  end

  // Pointer, occupancy and storage update: push at the tail and pop the drained entries at the head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      // NOTE: storage is reset on purpose so the idle head-window drives zeros onto the write ports.
      for (int i = 0; i < DEPTH; i++) begin
        memAddr[i] <= '0;
        memData[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments, so every update below uses this cycle's values.
      if (push) begin
        memAddr[tail] <= inAddr;
        memData[tail] <= inData;
        tail          <= tail + 1'b1;
      end
      head  <= head + popCount[PTR_WIDTH-1:0];
      count <= count + CNT_WIDTH'(push) - popCount;
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue with the default parameters (32 regs, 32-bit data, 2 ports, depth 8).
// Queue fills are done under stall, so the vector table holds for both build variants.
// The bypass-specific sequence has one expectation set per variant.
module tb_regfile_wb_queue;

  logic             clk;
  logic             rst;
  logic             inValid;
  logic             inReady;
  logic [4:0]       inAddr;
  logic [31:0]      inData;
  logic             stall;
  logic             en;
  logic [1:0]       we;
  logic [1:0][4:0]  wAddrs;
  logic [1:0][31:0] wPorts;
  logic [4:0]       qAddr;
  logic             qHit;
  logic [31:0]      qData;
  logic [3:0]       count;

  int vectorsApplied = 0;
  int miscompares    = 0;
  logic [31:0] rfModel [32];

  typedef struct {
    logic        inValid;
    logic [4:0]  inAddr;
    logic [31:0] inData;
    logic        stall;
    logic [4:0]  qAddr;
    logic        expReady;
    logic [1:0]  expWe;
    logic [4:0]  expA0;
    logic [31:0] expD0;
    logic [4:0]  expA1;
    logic [31:0] expD1;
    logic [3:0]  expCount;
    logic        expHit;
    logic [31:0] expQData;
  } vec_t;

  vec_t vecs[$];

  regfile_wb_queue dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .inAddr(inAddr),
    .inData(inData), .stall(stall), .en(en), .we(we), .wAddrs(wAddrs), .wPorts(wPorts),
    .qAddr(qAddr), .qHit(qHit), .qData(qData), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: commits whatever the write ports carry at each rising edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (we[i]) rfModel[wAddrs[i]] <= wPorts[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectorsApplied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [4:0] a, input logic [31:0] d,
                              input logic s, input logic [4:0] q, input logic rdy,
                              input logic [1:0] w, input logic [4:0] a0, input logic [31:0] d0,
                              input logic [4:0] a1, input logic [31:0] d1, input logic [3:0] c,
                              input logic h, input logic [31:0] qd);
    vec_t r;
    r.inValid = v;  r.inAddr = a;  r.inData = d;  r.stall = s;  r.qAddr = q;
    r.expReady = rdy; r.expWe = w; r.expA0 = a0; r.expD0 = d0; r.expA1 = a1; r.expD1 = d1;
    r.expCount = c; r.expHit = h; r.expQData = qd;
    return r;
  endfunction

  task automatic applyVec(input int n, input vec_t v);
    @(negedge clk);
    inValid = v.inValid; inAddr = v.inAddr; inData = v.inData; stall = v.stall; qAddr = v.qAddr;
    #2;
    check($sformatf("v%0d inReady", n), inReady, v.expReady);
    check($sformatf("v%0d we", n), we, v.expWe);
    check($sformatf("v%0d en", n), en, |v.expWe);
    check($sformatf("v%0d count", n), count, v.expCount);
    check($sformatf("v%0d qHit", n), qHit, v.expHit);
    check($sformatf("v%0d qData", n), qData, v.expQData);
    if (v.expWe[0]) begin
      check($sformatf("v%0d wAddrs0", n), wAddrs[0], v.expA0);
      check($sformatf("v%0d wPorts0", n), wPorts[0], v.expD0);
    end
    if (v.expWe[1]) begin
      check($sformatf("v%0d wAddrs1", n), wAddrs[1], v.expA1);
      check($sformatf("v%0d wPorts1", n), wPorts[1], v.expD1);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, " inReady"}, inReady, 1'b1);
    check({tag, " en"}, en, 1'b0);
    check({tag, " we"}, we, 2'b00);
    check({tag, " wAddrs"}, wAddrs, 10'd0);
    check({tag, " wPorts"}, wPorts, 64'd0);
    check({tag, " qHit"}, qHit, 1'b0);
    check({tag, " qData"}, qData, 32'd0);
    check({tag, " count"}, count, 4'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rfModel[i] = 32'd0;
    rst = 1'b0; inValid = 1'b0; inAddr = '0; inData = '0; stall = 1'b0; qAddr = '0;

    // Ordering: two pushes under stall, then a single two-port drain.
    vecs.push_back(mk(1, 0, 32'hFFFFFFFF, 1, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 32'hCCCCCCCC, 1, 0, 1, 2'b00, 0, 0, 0, 0, 1, 1, 32'hFFFFFFFF));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 2'b00, 0, 0, 0, 0, 2, 1, 32'hCCCCCCCC));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 2'b00, 0, 0, 0, 0, 2, 1, 32'hCCCCCCCC));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2'b11, 0, 32'hFFFFFFFF, 1, 32'hCCCCCCCC, 2, 1, 32'hFFFFFFFF));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    // Same-address collision: r5 drains over two cycles.
    vecs.push_back(mk(1, 5, 1, 1, 5, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 5, 2, 1, 5, 1, 2'b00, 0, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 5, 1, 2'b01, 5, 1, 0, 0, 2, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 5, 1, 2'b01, 5, 2, 0, 0, 1, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 5, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    // Forwarding: the youngest r3 wins, and a miss returns 0.
    vecs.push_back(mk(1, 3, 32'hA, 1, 3, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 7, 32'hB, 1, 3, 1, 2'b00, 0, 0, 0, 0, 1, 1, 32'hA));
    vecs.push_back(mk(1, 3, 32'hC, 1, 7, 1, 2'b00, 0, 0, 0, 0, 2, 1, 32'hB));
    vecs.push_back(mk(0, 0, 0, 1, 3, 1, 2'b00, 0, 0, 0, 0, 3, 1, 32'hC));
    vecs.push_back(mk(0, 0, 0, 1, 4, 1, 2'b00, 0, 0, 0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 3, 1, 2'b11, 3, 32'hA, 7, 32'hB, 3, 1, 32'hC));
    vecs.push_back(mk(0, 0, 0, 0, 3, 1, 2'b01, 3, 32'hC, 0, 0, 1, 1, 32'hC));
    vecs.push_back(mk(0, 0, 0, 0, 3, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    // Full queue: head and tail start at index 7, so the fill and the drain both wrap.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 5'(10 + i), 32'h100 + 32'(i), 1, 0, 1, 2'b00, 0, 0, 0, 0, 4'(i), 0, 0));
    vecs.push_back(mk(1, 20, 32'hDEAD, 1, 17, 0, 2'b00, 0, 0, 0, 0, 8, 1, 32'h107));
    vecs.push_back(mk(1, 20, 32'hDEAD, 0, 20, 0, 2'b11, 10, 32'h100, 11, 32'h101, 8, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 20, 1, 2'b11, 12, 32'h102, 13, 32'h103, 6, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 20, 1, 2'b11, 14, 32'h104, 15, 32'h105, 4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 20, 1, 2'b11, 16, 32'h106, 17, 32'h107, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 20, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0));

    // Reset state while rst is held low.
    repeat (2) @(negedge clk);
    #2 checkResetOutputs("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int n = 0; n < vecs.size(); n++) applyVec(n, vecs[n]);

    @(negedge clk);
    inValid = 1'b0; stall = 1'b0;
    #2;
    check("rf r0", rfModel[0], 32'hFFFFFFFF);
    check("rf r1", rfModel[1], 32'hCCCCCCCC);
    check("rf r5", rfModel[5], 32'd2);
    check("rf r3", rfModel[3], 32'hC);
    check("rf r7", rfModel[7], 32'hB);
    check("rf r20 untouched", rfModel[20], 32'd0);
    for (int i = 0; i < 8; i++)
      check($sformatf("rf r%0d", 10 + i), rfModel[10 + i], 32'h100 + 32'(i));

    // Empty, unstalled push: bypass in one variant, single-cycle FIFO latency in the other.
    @(negedge clk);
    inValid = 1'b1; inAddr = 5'd9; inData = 32'h1234; stall = 1'b0; qAddr = 5'd9;
    #2;
`ifdef WB_BYPASS_EN
    check("byp we", we, 2'b01);
    check("byp en", en, 1'b1);
    check("byp wAddrs0", wAddrs[0], 5'd9);
    check("byp wPorts0", wPorts[0], 32'h1234);
    check("byp qHit", qHit, 1'b0);
    @(negedge clk);
    inValid = 1'b0;
    #2;
    check("byp count after", count, 4'd0);
    check("byp we after", we, 2'b00);
`else
    check("lat we same cycle", we, 2'b00);
    check("lat count same cycle", count, 4'd0);
    @(negedge clk);
    inValid = 1'b0;
    #2;
    check("lat count", count, 4'd1);
    check("lat we", we, 2'b01);
    check("lat wAddrs0", wAddrs[0], 5'd9);
    check("lat wPorts0", wPorts[0], 32'h1234);
    check("lat qHit", qHit, 1'b1);
    @(negedge clk);
    #2;
    check("lat count after", count, 4'd0);
`endif
    check("rf r9", rfModel[9], 32'h1234);

    // Reset mid-operation: three queued writes are discarded.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      inValid = 1'b1; inAddr = 5'(25 + i); inData = 32'h250 + 32'(i); stall = 1'b1; qAddr = 5'd25;
    end
    @(negedge clk);
    inValid = 1'b0;
    #2;
    check("pre-reset count", count, 4'd3);
    check("pre-reset qHit", qHit, 1'b1);
    rst = 1'b0;
    #1 checkResetOutputs("midreset");
    @(negedge clk);
    rst = 1'b1; stall = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #2;
      check($sformatf("post-reset en c%0d", c), en, 1'b0);
      check($sformatf("post-reset count c%0d", c), count, 4'd0);
    end
    check("rf r25 untouched", rfModel[25], 32'd0);
    check("rf r27 untouched", rfModel[27], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
